// File: rtl/registered_alu_acc_p.sv
// Handshaked accumulator ALU with a shift-add multiplier and sticky overflow flag.
// Optional feature: define ALU_SAT_EN to clamp overflowing ADD/SUB results.
module registered_alu_acc_p #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [2:0]       i_sel,
    output logic [WIDTH-1:0] o_result,
    output logic             o_valid,
    output logic             o_carry,
    output logic             o_ovf,
    output logic             o_ovf_sticky
);

    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef ALU_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_MAX   = 3'b010,
        OP_MIN   = 3'b011,
        OP_LOAD  = 3'b100,
        OP_CLEAR = 3'b101,
        OP_MUL   = 3'b110,
        OP_NOP   = 3'b111
    } op_t;

    state_t             state_q, state_d;
    op_t                sel_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand, mplier, prod;
    logic [CNT_W-1:0]   cnt;

    logic               is_sub;
    logic [WIDTH-1:0]   opnd_b;
    logic [WIDTH:0]     sum_ext;
    logic               add_ovf;
    logic               a_gt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic [WIDTH-1:0]   prod_step;
    logic               mul_last;

    assign o_ready  = (state_q == ST_IDLE);
    assign o_result = acc;
    assign mul_last = (cnt == CNT_W'(WIDTH - 1));

    // SUB is a + ~acc + 1, so the same adder serves both ops.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        alu_res   = acc;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        is_sub    = (sel_reg == OP_SUB);
        opnd_b    = is_sub ? ~acc : acc;
        sum_ext   = {1'b0, a_reg} + {1'b0, opnd_b} + {{WIDTH{1'b0}}, is_sub};
        add_ovf   = (a_reg[WIDTH-1] == opnd_b[WIDTH-1]) &&
                    (sum_ext[WIDTH-1] != a_reg[WIDTH-1]);
        a_gt      = $signed(a_reg) > $signed(acc);

        case (sel_reg)
            OP_ADD, OP_SUB: begin
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = add_ovf;
                alu_res   = sum_ext[WIDTH-1:0];
`ifdef ALU_SAT_EN
                if (add_ovf)
                    alu_res = a_reg[WIDTH-1] ? SAT_NEG : SAT_POS;
`endif
            end
            OP_MAX:         alu_res = a_gt ? a_reg : acc;
            OP_MIN:         alu_res = a_gt ? acc : a_reg;
            OP_LOAD:        alu_res = a_reg;
            OP_CLEAR:       alu_res = ACC_INIT;
            OP_MUL, OP_NOP: alu_res = acc;
        endcase
    end

    assign prod_step = mplier[0] ? (prod + mcand) : prod;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_valid && o_ready) state_d = ST_EXEC;
            ST_EXEC: state_d = (sel_reg == OP_MUL) ? ST_MUL : ST_IDLE;
            ST_MUL:  if (mul_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sel_reg      <= OP_NOP;
            a_reg        <= '0;
            acc          <= ACC_INIT;
            mcand        <= '0;
            mplier       <= '0;
            prod         <= '0;
            cnt          <= '0;
            o_valid      <= 1'b0;
            o_carry      <= 1'b0;
            o_ovf        <= 1'b0;
            o_ovf_sticky <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_valid && o_ready) begin
                        a_reg   <= i_a;
                        sel_reg <= op_t'(i_sel);
                    end
                end
                ST_EXEC: begin
                    if (sel_reg == OP_MUL) begin
                        mcand  <= acc;
                        mplier <= a_reg;
                        prod   <= '0;
                        cnt    <= '0;
                    end else begin
                        acc          <= alu_res;
                        o_carry      <= alu_carry;
                        o_ovf        <= alu_ovf;
                        o_ovf_sticky <= (sel_reg == OP_CLEAR) ? 1'b0
                                                              : (o_ovf_sticky | alu_ovf);
                        o_valid      <= 1'b1;
                    end
                end
                ST_MUL: begin
                    // Only the low WIDTH product bits are kept, which equal the signed product mod 2^WIDTH.
                    prod   <= prod_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (mul_last) begin
                        acc     <= prod_step;
                        o_carry <= 1'b0;
                        o_ovf   <= 1'b0;
                        o_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_registered_alu_acc_p.sv
// Randomised bench for registered_alu_acc_p against an integer-arithmetic accumulator model.
// Build with ALU_SAT_EN defined to check the saturating variant.
module tb_registered_alu_acc_p;

    localparam int W    = 8;
    localparam int MAXS = (1 << (W - 1)) - 1;
    localparam int MINS = -(1 << (W - 1));

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MAX = 3'b010, MIN = 3'b011,
                           LOAD = 3'b100, CLEAR = 3'b101, MUL = 3'b110, NOP = 3'b111;

    logic         i_clk, i_reset, i_valid, o_ready;
    logic [W-1:0] i_a, o_result;
    logic [2:0]   i_sel;
    logic         o_valid, o_carry, o_ovf, o_ovf_sticky;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_acc;
    logic         m_carry, m_ovf, m_sticky;

    registered_alu_acc_p #(.WIDTH(W), .ACC_INIT('0)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_sel(i_sel), .o_result(o_result), .o_valid(o_valid),
        .o_carry(o_carry), .o_ovf(o_ovf), .o_ovf_sticky(o_ovf_sticky)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: signed integer arithmetic, range test for overflow, result taken mod 2^W.
    task automatic model_op(input logic [2:0] sel, input logic [W-1:0] a);
        int sa, sacc, ua, uacc, raw;
        sa      = $signed(a);
        sacc    = $signed(m_acc);
        ua      = int'(a);
        uacc    = int'(m_acc);
        m_carry = 1'b0;
        m_ovf   = 1'b0;
        raw     = sacc;
        case (sel)
            ADD: begin
                raw     = sa + sacc;
                m_carry = (ua + uacc) >= (1 << W);
                m_ovf   = (raw > MAXS) || (raw < MINS);
            end
            SUB: begin
                raw     = sa - sacc;
                m_carry = (ua >= uacc);
                m_ovf   = (raw > MAXS) || (raw < MINS);
            end
            MAX:   raw = (sa > sacc) ? sa : sacc;
            MIN:   raw = (sa < sacc) ? sa : sacc;
            LOAD:  raw = sa;
            CLEAR: raw = 0;
            MUL:   raw = sa * sacc;
            default: raw = sacc;
        endcase
`ifdef ALU_SAT_EN
        if (m_ovf) raw = (raw > 0) ? MAXS : MINS;
`endif
        m_acc    = raw[W-1:0];
        m_sticky = (sel == CLEAR) ? 1'b0 : (m_sticky | m_ovf);
    endtask

    task automatic model_reset();
        m_acc    = '0;
        m_carry  = 1'b0;
        m_ovf    = 1'b0;
        m_sticky = 1'b0;
    endtask

    // Issue one op, throw junk at the busy block, then check latency, result and flags.
    task automatic run_op(input logic [2:0] sel, input logic [W-1:0] a);
        int cyc, busy, exp_lat;
        @(negedge i_clk);
        check("ready_before", o_ready, 1);
        i_valid = 1'b1;
        i_sel   = sel;
        i_a     = a;
        model_op(sel, a);
        exp_lat = (sel == MUL) ? W + 1 : 1;
        @(negedge i_clk);
        cyc  = 0;
        busy = 0;
        while (cyc < 40) begin
            if (!o_ready) busy++;
            if (o_valid) break;
            if (!o_ready && $urandom_range(0, 1) == 1) begin
                i_valid = 1'b1;
                i_sel   = 3'($urandom);
                i_a     = W'($urandom);
            end else begin
                i_valid = 1'b0;
            end
            @(negedge i_clk);
            cyc++;
        end
        i_valid = 1'b0;
        check("latency", cyc, exp_lat);
        check("busy_cycles", busy, exp_lat);
        check("valid", o_valid, 1);
        check("result", o_result, m_acc);
        check("carry", o_carry, m_carry);
        check("ovf", o_ovf, m_ovf);
        check("sticky", o_ovf_sticky, m_sticky);
        @(negedge i_clk);
        check("valid_pulse", o_valid, 0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_a     = '0;
        i_sel   = NOP;
        model_reset();
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        check("rst_result", o_result, 0);
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_flags", {o_carry, o_ovf, o_ovf_sticky}, 0);
        @(negedge i_clk);
        check("idle_valid", o_valid, 0);

        // T1
        run_op(ADD, 8'd17);
        run_op(ADD, 8'd75);
        run_op(ADD, -8'sd63);
        run_op(ADD, -8'sd36);
        check("t1_result", o_result, 8'hF9);

        // T2
        run_op(CLEAR, 8'd0);
        run_op(ADD, 8'd93);
        run_op(ADD, 8'd93);
`ifdef ALU_SAT_EN
        check("t2_result", o_result, 8'h7F);
`else
        check("t2_result", o_result, 8'hBA);
`endif
        check("t2_sticky", o_ovf_sticky, 1);

        // T3
        run_op(LOAD, -8'sd63);
        run_op(SUB, 8'd75);
        run_op(CLEAR, 8'd0);
        check("t3_sticky", o_ovf_sticky, 0);

        // T4
        run_op(LOAD, 8'd27);
        run_op(MAX, 8'd67);
        run_op(MAX, 8'd36);
        run_op(MIN, 8'd17);
        run_op(MIN, -8'sd5);
        check("t4_result", o_result, 8'hFB);

        // T5
        run_op(LOAD, 8'd6);
        run_op(MUL, -8'sd7);
        check("t5_result", o_result, 8'hD6);

        // T6: raise sticky first so the reset has something to clear
        run_op(LOAD, 8'd100);
        run_op(ADD, 8'd100);
        run_op(LOAD, 8'd6);
        @(negedge i_clk);
        i_valid = 1'b1;
        i_sel   = MUL;
        i_a     = 8'd5;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        check("t6_busy", o_ready, 0);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        model_reset();
        check("t6_result", o_result, 0);
        check("t6_ready", o_ready, 1);
        check("t6_valid", o_valid, 0);
        check("t6_flags", {o_carry, o_ovf, o_ovf_sticky}, 0);

        // Random ops, biased towards arithmetic near the overflow boundary
        for (int i = 0; i < 300; i++) begin
            logic [2:0]   sel;
            logic [W-1:0] a;
            sel = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       a = 8'h7F - 8'($urandom_range(0, 3));
                1:       a = 8'h80 + 8'($urandom_range(0, 3));
                default: a = W'($urandom);
            endcase
            run_op(sel, a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
